// File: rtl/decode_control_pipe_pkg.sv
// Shared types for the RV32I decode stage: control word, encodings, ALU ops,
// opcode constants and small instruction field helpers.
package decode_control_pipe_pkg;

  typedef logic [31:0] instruction_type;

  typedef enum logic [2:0] {
    R_TYPE = 3'd0,
    I_TYPE = 3'd1,
    S_TYPE = 3'd2,
    B_TYPE = 3'd3,
    U_TYPE = 3'd4
  } encoding_type;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'd0,
    ALU_SUB   = 4'd1,
    ALU_SLL   = 4'd2,
    ALU_SRL   = 4'd3,
    ALU_SRA   = 4'd4,
    ALU_XOR   = 4'd5,
    ALU_OR    = 4'd6,
    ALU_AND   = 4'd7,
    ALU_SLT   = 4'd8,
    ALU_SLTU  = 4'd9,
    ALU_PASSB = 4'd10
  } alu_op_type;

  typedef enum logic {
    BR_EQ = 1'b0,
    BR_NE = 1'b1
  } branch_cond_type;

  // All-zero value is the "do nothing" control used for illegal encodings.
  typedef struct packed {
    encoding_type    encoding;
    logic            RegWrite;
    logic            ALUSrc;
    alu_op_type      ALUOp;
    logic            MemRead;
    logic            MemWrite;
    logic            MemtoReg;
    logic            Branch;
    branch_cond_type BranchCond;
  } control_type;

  // Which update the output register performs this cycle, in priority order.
  typedef enum logic [2:0] {
    ACT_HOLD   = 3'd0,
    ACT_FLUSH  = 3'd1,
    ACT_BUBBLE = 3'd2,
    ACT_LOAD   = 3'd3,
    ACT_DRAIN  = 3'd4
  } pipe_act_type;

  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  function automatic logic [4:0] rs1_field(input instruction_type instr);
    return instr[19:15];
  endfunction

  function automatic logic [4:0] rs2_field(input instruction_type instr);
    return instr[24:20];
  endfunction

  function automatic logic [4:0] rd_field(input instruction_type instr);
    return instr[11:7];
  endfunction

endpackage

// File: rtl/decode_control_pipe_decode.sv
// Purely combinational RV32I-subset decoder: control word, sign-extended
// immediate, source-register usage flags and an illegal flag.
module decode_comb
  import decode_control_pipe_pkg::*;
#(
  parameter int XLEN          = 32,
  parameter bit ENABLE_MEM    = 1'b1,
  parameter bit ENABLE_BRANCH = 1'b1
) (
  input  instruction_type   instr_i,
  output control_type       ctrl_o,
  output logic [XLEN-1:0]   imm_o,
  output logic              rs1_used_o,
  output logic              rs2_used_o,
  output logic              illegal_o
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       shift_zero_ok;
  logic       shift_arith_ok;

  logic signed [11:0] imm_i12;
  logic signed [11:0] imm_s12;
  logic signed [12:0] imm_b13;
  logic signed [31:0] imm_u32;

  assign opcode = instr_i[6:0];
  assign funct3 = instr_i[14:12];
  assign funct7 = instr_i[31:25];

  // At XLEN=64 funct7[0] is shamt[5], so only the upper six bits qualify.
  assign shift_zero_ok  = (XLEN == 32) ? (funct7 == 7'b0000000)
                                       : (funct7[6:1] == 6'b000000);
  assign shift_arith_ok = (XLEN == 32) ? (funct7 == 7'b0100000)
                                       : (funct7[6:1] == 6'b010000);

  assign imm_i12 = instr_i[31:20];
  assign imm_s12 = {instr_i[31:25], instr_i[11:7]};
  assign imm_b13 = {instr_i[31], instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};
  assign imm_u32 = {instr_i[31:12], 12'b0};

  always_comb begin
    ctrl_o     = '0;
    imm_o      = '0;
    rs1_used_o = 1'b0;
    rs2_used_o = 1'b0;
    illegal_o  = 1'b1;

    case (opcode)
      OP_REG: begin
        if ((funct7 == 7'b0000000) ||
            ((funct7 == 7'b0100000) && ((funct3 == 3'b000) || (funct3 == 3'b101)))) begin
          illegal_o          = 1'b0;
          rs1_used_o         = 1'b1;
          rs2_used_o         = 1'b1;
          ctrl_o.encoding    = R_TYPE;
          ctrl_o.RegWrite    = 1'b1;
          case (funct3)
            3'b000:  ctrl_o.ALUOp = funct7[5] ? ALU_SUB : ALU_ADD;
            3'b001:  ctrl_o.ALUOp = ALU_SLL;
            3'b010:  ctrl_o.ALUOp = ALU_SLT;
            3'b011:  ctrl_o.ALUOp = ALU_SLTU;
            3'b100:  ctrl_o.ALUOp = ALU_XOR;
            3'b101:  ctrl_o.ALUOp = funct7[5] ? ALU_SRA : ALU_SRL;
            3'b110:  ctrl_o.ALUOp = ALU_OR;
            default: ctrl_o.ALUOp = ALU_AND;
          endcase
        end
      end

      OP_IMM: begin
        if (((funct3 != 3'b001) && (funct3 != 3'b101)) ||
            ((funct3 == 3'b001) && shift_zero_ok) ||
            ((funct3 == 3'b101) && (shift_zero_ok || shift_arith_ok))) begin
          illegal_o       = 1'b0;
          rs1_used_o      = 1'b1;
          imm_o           = XLEN'(imm_i12);
          ctrl_o.encoding = I_TYPE;
          ctrl_o.RegWrite = 1'b1;
          ctrl_o.ALUSrc   = 1'b1;
          case (funct3)
            3'b000:  ctrl_o.ALUOp = ALU_ADD;
            3'b001:  ctrl_o.ALUOp = ALU_SLL;
            3'b010:  ctrl_o.ALUOp = ALU_SLT;
            3'b011:  ctrl_o.ALUOp = ALU_SLTU;
            3'b100:  ctrl_o.ALUOp = ALU_XOR;
            3'b101:  ctrl_o.ALUOp = shift_arith_ok ? ALU_SRA : ALU_SRL;
            3'b110:  ctrl_o.ALUOp = ALU_OR;
            default: ctrl_o.ALUOp = ALU_AND;
          endcase
        end
      end

      OP_LOAD: begin
        if (ENABLE_MEM && (funct3 == 3'b010)) begin
          illegal_o       = 1'b0;
          rs1_used_o      = 1'b1;
          imm_o           = XLEN'(imm_i12);
          ctrl_o.encoding = I_TYPE;
          ctrl_o.RegWrite = 1'b1;
          ctrl_o.ALUSrc   = 1'b1;
          ctrl_o.ALUOp    = ALU_ADD;
          ctrl_o.MemRead  = 1'b1;
          ctrl_o.MemtoReg = 1'b1;
        end
      end

      OP_STORE: begin
        if (ENABLE_MEM && (funct3 == 3'b010)) begin
          illegal_o       = 1'b0;
          rs1_used_o      = 1'b1;
          rs2_used_o      = 1'b1;
          imm_o           = XLEN'(imm_s12);
          ctrl_o.encoding = S_TYPE;
          ctrl_o.ALUSrc   = 1'b1;
          ctrl_o.ALUOp    = ALU_ADD;
          ctrl_o.MemWrite = 1'b1;
        end
      end

      OP_BRANCH: begin
        if (ENABLE_BRANCH && ((funct3 == 3'b000) || (funct3 == 3'b001))) begin
          illegal_o         = 1'b0;
          rs1_used_o        = 1'b1;
          rs2_used_o        = 1'b1;
          imm_o             = XLEN'(imm_b13);
          ctrl_o.encoding   = B_TYPE;
          ctrl_o.ALUOp      = ALU_SUB;
          ctrl_o.Branch     = 1'b1;
          ctrl_o.BranchCond = funct3[0] ? BR_NE : BR_EQ;
        end
      end

      OP_LUI: begin
        illegal_o       = 1'b0;
        imm_o           = XLEN'(imm_u32);
        ctrl_o.encoding = U_TYPE;
        ctrl_o.RegWrite = 1'b1;
        ctrl_o.ALUSrc   = 1'b1;
        ctrl_o.ALUOp    = ALU_PASSB;
      end

      default: ;
    endcase
  end

endmodule

// File: rtl/decode_control_pipe.sv
// Registered decode stage between fetch and execute: one-entry output register
// with load-use bubbling, synchronous flush and a saturating bubble counter.
module decode_control_pipe
  import decode_control_pipe_pkg::*;
#(
  parameter int XLEN          = 32,
  parameter bit ENABLE_MEM    = 1'b1,
  parameter bit ENABLE_BRANCH = 1'b1,
  parameter int STALL_CNT_W   = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  instruction_type        in_instruction,
  input  logic [XLEN-1:0]        in_pc,
  input  logic                   flush,
  output logic                   out_valid,
  input  logic                   out_ready,
  output control_type            out_control,
  output logic [XLEN-1:0]        out_imm,
  output logic [XLEN-1:0]        out_pc,
  output logic [4:0]             out_rs1,
  output logic [4:0]             out_rs2,
  output logic [4:0]             out_rd,
  output logic                   out_illegal,
  output logic                   load_use_stall,
  output logic [STALL_CNT_W-1:0] stall_count
);

  // Handshake: a transfer happens on a rising edge where valid and ready are
  // both high; a producer holding valid keeps its payload stable until then.

  control_type      dec_ctrl;
  logic [XLEN-1:0]  dec_imm;
  logic             dec_rs1_used;
  logic             dec_rs2_used;
  logic             dec_illegal;

  logic                   valid_q,   valid_d;
  control_type            ctrl_q,    ctrl_d;
  logic [XLEN-1:0]        imm_q,     imm_d;
  logic [XLEN-1:0]        pc_q,      pc_d;
  logic [4:0]             rs1_q,     rs1_d;
  logic [4:0]             rs2_q,     rs2_d;
  logic [4:0]             rd_q,      rd_d;
  logic                   illegal_q, illegal_d;
  logic [STALL_CNT_W-1:0] cnt_q,     cnt_d;

  logic         hazard;
  pipe_act_type act;

  decode_comb #(
    .XLEN          (XLEN),
    .ENABLE_MEM    (ENABLE_MEM),
    .ENABLE_BRANCH (ENABLE_BRANCH)
  ) u_decode (
    .instr_i    (in_instruction),
    .ctrl_o     (dec_ctrl),
    .imm_o      (dec_imm),
    .rs1_used_o (dec_rs1_used),
    .rs2_used_o (dec_rs2_used),
    .illegal_o  (dec_illegal)
  );

  // The held load writes a register the offered instruction reads next cycle.
  assign hazard = valid_q && ctrl_q.MemRead && (rd_q != 5'd0) && in_valid &&
                  ((dec_rs1_used && (rs1_field(in_instruction) == rd_q)) ||
                   (dec_rs2_used && (rs2_field(in_instruction) == rd_q)));

  assign in_ready       = (!valid_q || out_ready) && !hazard && !flush;
  assign load_use_stall = hazard && out_ready && !flush;

  always_comb begin
    act = ACT_HOLD;
    if (flush) begin
      act = ACT_FLUSH;
    end else if (hazard && out_ready) begin
      act = ACT_BUBBLE;
    end else if (in_valid && in_ready) begin
      act = ACT_LOAD;
    end else if (out_ready && !in_valid) begin
      act = ACT_DRAIN;
    end
  end

  always_comb begin
    valid_d   = valid_q;
    ctrl_d    = ctrl_q;
    imm_d     = imm_q;
    pc_d      = pc_q;
    rs1_d     = rs1_q;
    rs2_d     = rs2_q;
    rd_d      = rd_q;
    illegal_d = illegal_q;
    cnt_d     = cnt_q;

    case (act)
      ACT_FLUSH, ACT_DRAIN: begin
        valid_d = 1'b0;
      end
      ACT_BUBBLE: begin
        valid_d = 1'b0;
        if (cnt_q != '1) begin
          cnt_d = cnt_q + STALL_CNT_W'(1);
        end
      end
      ACT_LOAD: begin
        valid_d   = 1'b1;
        ctrl_d    = dec_ctrl;
        imm_d     = dec_imm;
        pc_d      = in_pc;
        rs1_d     = rs1_field(in_instruction);
        rs2_d     = rs2_field(in_instruction);
        rd_d      = rd_field(in_instruction);
        illegal_d = dec_illegal;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q   <= 1'b0;
      ctrl_q    <= '0;
      imm_q     <= '0;
      pc_q      <= '0;
      rs1_q     <= '0;
      rs2_q     <= '0;
      rd_q      <= '0;
      illegal_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      valid_q   <= valid_d;
      ctrl_q    <= ctrl_d;
      imm_q     <= imm_d;
      pc_q      <= pc_d;
      rs1_q     <= rs1_d;
      rs2_q     <= rs2_d;
      rd_q      <= rd_d;
      illegal_q <= illegal_d;
      cnt_q     <= cnt_d;
    end
  end

  assign out_valid   = valid_q;
  assign out_control = ctrl_q;
  assign out_imm     = imm_q;
  assign out_pc      = pc_q;
  assign out_rs1     = rs1_q;
  assign out_rs2     = rs2_q;
  assign out_rd      = rd_q;
  assign out_illegal = illegal_q;
  assign stall_count = cnt_q;

endmodule

// File: tb/tb_decode_control_pipe.sv
// Bench for decode_control_pipe: directed scenarios plus randomized traffic
// checked against a mask/match instruction-table reference model.
module tb_decode_control_pipe;
  import decode_control_pipe_pkg::*;

  localparam int XLEN    = 32;
  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;
  localparam int N_OPS   = 24;

  // Ops 0-9 R-type, 10-15 I-arith, 16-18 shift-imm, 19 LW, 20 SW, 21 BEQ, 22 BNE, 23 LUI.
  localparam logic [31:0] OP_MASK [N_OPS] = '{
    32'hFE00707F, 32'hFE00707F, 32'hFE00707F, 32'hFE00707F, 32'hFE00707F,
    32'hFE00707F, 32'hFE00707F, 32'hFE00707F, 32'hFE00707F, 32'hFE00707F,
    32'h0000707F, 32'h0000707F, 32'h0000707F, 32'h0000707F, 32'h0000707F, 32'h0000707F,
    32'hFE00707F, 32'hFE00707F, 32'hFE00707F,
    32'h0000707F, 32'h0000707F, 32'h0000707F, 32'h0000707F, 32'h0000007F};
  localparam logic [31:0] OP_MATCH [N_OPS] = '{
    32'h00000033, 32'h40000033, 32'h00001033, 32'h00002033, 32'h00003033,
    32'h00004033, 32'h00005033, 32'h40005033, 32'h00006033, 32'h00007033,
    32'h00000013, 32'h00002013, 32'h00003013, 32'h00004013, 32'h00006013, 32'h00007013,
    32'h00001013, 32'h00005013, 32'h40005013,
    32'h00002003, 32'h00002023, 32'h00000063, 32'h00001063, 32'h00000037};

  typedef struct packed {
    control_type ctl;
    logic [31:0] imm;
    logic        use1;
    logic        use2;
    logic        ill;
  } ref_t;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [31:0]       in_instruction;
  logic [XLEN-1:0]   in_pc;
  logic              flush;
  logic              out_valid;
  logic              out_ready;
  control_type       out_control;
  logic [XLEN-1:0]   out_imm;
  logic [XLEN-1:0]   out_pc;
  logic [4:0]        out_rs1;
  logic [4:0]        out_rs2;
  logic [4:0]        out_rd;
  logic              out_illegal;
  logic              load_use_stall;
  logic [CNT_W-1:0]  stall_count;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference state: the instruction the stage should be holding, and the bubble count.
  logic        m_valid;
  ref_t        m_ref;
  logic [31:0] m_ins;
  logic [31:0] m_pc;
  int          m_cnt;

  // Inputs driven for the current cycle and what they should produce.
  logic        p_v, p_ordy, p_fl;
  logic [31:0] p_ins, p_pc;
  ref_t        p_ref;
  logic        e_haz, e_ready, e_stall;

  decode_control_pipe #(
    .XLEN          (XLEN),
    .ENABLE_MEM    (1'b1),
    .ENABLE_BRANCH (1'b1),
    .STALL_CNT_W   (CNT_W)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_instruction (in_instruction),
    .in_pc          (in_pc),
    .flush          (flush),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_control    (out_control),
    .out_imm        (out_imm),
    .out_pc         (out_pc),
    .out_rs1        (out_rs1),
    .out_rs2        (out_rs2),
    .out_rd         (out_rd),
    .out_illegal    (out_illegal),
    .load_use_stall (load_use_stall),
    .stall_count    (stall_count)
  );

  always #5 clk = ~clk;

  function automatic alu_op_type alu_of(input int id);
    case (id)
      1:       return ALU_SUB;
      2, 16:   return ALU_SLL;
      3, 11:   return ALU_SLT;
      4, 12:   return ALU_SLTU;
      5, 13:   return ALU_XOR;
      6, 17:   return ALU_SRL;
      7, 18:   return ALU_SRA;
      8, 14:   return ALU_OR;
      9, 15:   return ALU_AND;
      default: return ALU_ADD;
    endcase
  endfunction

  function automatic ref_t ref_decode(input logic [31:0] ins);
    ref_t        r;
    int          id;
    logic [31:0] t;
    r  = '0;
    id = -1;
    t  = $signed(ins) >>> 20;
    for (int k = 0; k < N_OPS; k++) begin
      if ((ins & OP_MASK[k]) == OP_MATCH[k]) id = k;
    end
    if (id < 0) begin
      r.ill = 1'b1;
    end else if (id <= 9) begin
      r.ctl.encoding = R_TYPE; r.ctl.RegWrite = 1'b1; r.ctl.ALUOp = alu_of(id);
      r.use1 = 1'b1; r.use2 = 1'b1;
    end else if (id <= 18) begin
      r.ctl.encoding = I_TYPE; r.ctl.RegWrite = 1'b1; r.ctl.ALUSrc = 1'b1;
      r.ctl.ALUOp = alu_of(id); r.imm = t; r.use1 = 1'b1;
    end else if (id == 19) begin
      r.ctl.encoding = I_TYPE; r.ctl.RegWrite = 1'b1; r.ctl.ALUSrc = 1'b1;
      r.ctl.MemRead = 1'b1; r.ctl.MemtoReg = 1'b1; r.ctl.ALUOp = ALU_ADD;
      r.imm = t; r.use1 = 1'b1;
    end else if (id == 20) begin
      r.ctl.encoding = S_TYPE; r.ctl.MemWrite = 1'b1; r.ctl.ALUSrc = 1'b1;
      r.ctl.ALUOp = ALU_ADD;
      r.imm = (t & 32'hFFFFFFE0) | {27'b0, ins[11:7]};
      r.use1 = 1'b1; r.use2 = 1'b1;
    end else if (id <= 22) begin
      r.ctl.encoding = B_TYPE; r.ctl.Branch = 1'b1; r.ctl.ALUOp = ALU_SUB;
      r.ctl.BranchCond = (id == 22) ? BR_NE : BR_EQ;
      r.imm = (t & 32'hFFFFF7E0) | (32'(ins[7]) << 11) | (32'(ins[11:8]) << 1);
      r.use1 = 1'b1; r.use2 = 1'b1;
    end else begin
      r.ctl.encoding = U_TYPE; r.ctl.RegWrite = 1'b1; r.ctl.ALUSrc = 1'b1;
      r.ctl.ALUOp = ALU_PASSB; r.imm = ins & 32'hFFFFF000;
    end
    return r;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [4:0]  a, b, d;
    logic [11:0] im;
    logic [6:0]  f7;
    a  = 5'($urandom_range(0, 3));
    b  = 5'($urandom_range(0, 3));
    d  = 5'($urandom_range(0, 3));
    im = 12'($urandom);
    f7 = $urandom_range(0, 1) ? 7'h20 : 7'h00;
    case ($urandom_range(0, 8))
      0:       return {f7, b, a, 3'($urandom_range(0, 7)), d, 7'b0110011};
      1:       return {im, a, 3'($urandom_range(0, 7)), d, 7'b0010011};
      2, 3:    return {im, a, 3'b010, d, 7'b0000011};
      4:       return {im[11:5], b, a, 3'b010, im[4:0], 7'b0100011};
      5:       return {im[11:5], b, a, 3'($urandom_range(0, 1)), im[4:0], 7'b1100011};
      6:       return {20'($urandom), d, 7'b0110111};
      7:       return {($urandom_range(0, 2) == 2) ? 7'h01 : f7, b, a,
                       $urandom_range(0, 1) ? 3'b001 : 3'b101, d, 7'b0010011};
      default: return 32'($urandom);
    endcase
  endfunction

  task automatic model_reset();
    m_valid = 1'b0;
    m_ref   = '0;
    m_ins   = '0;
    m_pc    = '0;
    m_cnt   = 0;
  endtask

  task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                       input logic ordy, input logic fl);
    p_v = v; p_ins = ins; p_pc = pc; p_ordy = ordy; p_fl = fl;
    in_valid = v; in_instruction = ins; in_pc = pc; out_ready = ordy; flush = fl;
    p_ref   = ref_decode(ins);
    e_haz   = m_valid && m_ref.ctl.MemRead && (m_ins[11:7] != 5'd0) && v &&
              ((p_ref.use1 && (ins[19:15] == m_ins[11:7])) ||
               (p_ref.use2 && (ins[24:20] == m_ins[11:7])));
    e_ready = (!m_valid || ordy) && !e_haz && !fl;
    e_stall = e_haz && ordy && !fl;
  endtask

  task automatic advance();
    @(posedge clk);
    if (p_fl) begin
      m_valid = 1'b0;
    end else if (e_haz && p_ordy) begin
      m_valid = 1'b0;
      if (m_cnt < CNT_MAX) m_cnt++;
    end else if (p_v && e_ready) begin
      m_valid = 1'b1; m_ref = p_ref; m_ins = p_ins; m_pc = p_pc;
    end else if (p_ordy && !p_v) begin
      m_valid = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_tests++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    n_tests++;
    if (load_use_stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b want 0", load_use_stall); end
    rst = 1'b1;
    #1;
    n_tests++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_tests++;
    if (stall_count !== '0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", stall_count); end
    n_tests++;
    if ({out_control, out_imm, out_pc, out_rs1, out_rs2, out_rd, out_illegal} !== '0) begin
      n_fail++;
      $display("FAIL reset_fields: got ctl=%h imm=%h pc=%h rd=%0d ill=%b want all 0",
               out_control, out_imm, out_pc, out_rd, out_illegal);
    end
    @(negedge clk);
  endtask

  task automatic test_basic_decode();
    drive(1'b1, 32'h002081B3, 32'h100, 1'b1, 1'b0);
    advance();
    n_tests++;
    if (out_valid !== 1'b1 || out_control.ALUOp !== ALU_ADD || out_control.RegWrite !== 1'b1 ||
        out_control.ALUSrc !== 1'b0 || out_rd !== 5'd3 || out_illegal !== 1'b0) begin
      n_fail++;
      $display("FAIL add_decode: got v=%b alu=%0d rw=%b src=%b rd=%0d ill=%b want 1/0/1/0/3/0",
               out_valid, out_control.ALUOp, out_control.RegWrite, out_control.ALUSrc, out_rd, out_illegal);
    end
    n_tests++;
    if (out_pc !== 32'h100) begin n_fail++; $display("FAIL add_pc: got %h want 00000100", out_pc); end
  endtask

  task automatic test_imm_sign();
    drive(1'b1, 32'hFFF00293, 32'h104, 1'b1, 1'b0);
    advance();
    n_tests++;
    if (out_imm !== 32'hFFFFFFFF || out_control.ALUSrc !== 1'b1 || out_rs1 !== 5'd0) begin
      n_fail++;
      $display("FAIL addi_imm: got imm=%h src=%b rs1=%0d want ffffffff/1/0",
               out_imm, out_control.ALUSrc, out_rs1);
    end
  endtask

  task automatic test_load_use();
    drive(1'b1, 32'h0000A283, 32'h200, 1'b1, 1'b0);
    advance();
    drive(1'b1, 32'h00128333, 32'h204, 1'b1, 1'b0);
    #1;
    n_tests++;
    if (load_use_stall !== 1'b1 || in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL lu_stall: got stall=%b ready=%b want 1/0", load_use_stall, in_ready);
    end
    advance();
    n_tests++;
    if (out_valid !== 1'b0 || stall_count !== 4'd1) begin
      n_fail++;
      $display("FAIL lu_bubble: got v=%b cnt=%0d want 0/1", out_valid, stall_count);
    end
    drive(1'b1, 32'h00128333, 32'h204, 1'b1, 1'b0);
    advance();
    n_tests++;
    if (out_valid !== 1'b1 || out_rd !== 5'd6 || out_pc !== 32'h204) begin
      n_fail++;
      $display("FAIL lu_add: got v=%b rd=%0d pc=%h want 1/6/00000204", out_valid, out_rd, out_pc);
    end
  endtask

  task automatic test_backpressure();
    drive(1'b1, 32'hFFF00293, 32'h300, 1'b1, 1'b0);
    advance();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h002081B3, 32'h304, 1'b0, 1'b0);
      #1;
      n_tests++;
      if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready: got %b want 0", in_ready); end
      advance();
      n_tests++;
      if (out_valid !== 1'b1 || out_imm !== 32'hFFFFFFFF || out_pc !== 32'h300 ||
          out_rd !== 5'd5 || out_control !== m_ref.ctl) begin
        n_fail++;
        $display("FAIL bp_hold: got v=%b imm=%h pc=%h rd=%0d ctl=%h want 1/ffffffff/00000300/5/%h",
                 out_valid, out_imm, out_pc, out_rd, out_control, m_ref.ctl);
      end
    end
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    advance();
  endtask

  task automatic test_flush_hazard();
    int c0;
    drive(1'b1, 32'h0000A283, 32'h400, 1'b1, 1'b0);
    advance();
    c0 = m_cnt;
    drive(1'b1, 32'h00128333, 32'h404, 1'b1, 1'b1);
    #1;
    n_tests++;
    if (in_ready !== 1'b0 || load_use_stall !== 1'b0) begin
      n_fail++;
      $display("FAIL fl_comb: got ready=%b stall=%b want 0/0", in_ready, load_use_stall);
    end
    advance();
    n_tests++;
    if (out_valid !== 1'b0 || stall_count !== CNT_W'(c0)) begin
      n_fail++;
      $display("FAIL fl_result: got v=%b cnt=%0d want 0/%0d", out_valid, stall_count, c0);
    end
    drive(1'b1, 32'h00128333, 32'h404, 1'b1, 1'b0);
    #1;
    n_tests++;
    if (in_ready !== 1'b1 || load_use_stall !== 1'b0) begin
      n_fail++;
      $display("FAIL fl_after: got ready=%b stall=%b want 1/0", in_ready, load_use_stall);
    end
    advance();
  endtask

  task automatic test_illegal();
    drive(1'b1, 32'h00000000, 32'h500, 1'b1, 1'b0);
    advance();
    n_tests++;
    if (out_valid !== 1'b1 || out_illegal !== 1'b1 || out_control.RegWrite !== 1'b0 ||
        out_control.MemWrite !== 1'b0 || out_control.MemRead !== 1'b0) begin
      n_fail++;
      $display("FAIL illegal_zero: got v=%b ill=%b rw=%b mw=%b mr=%b want 1/1/0/0/0",
               out_valid, out_illegal, out_control.RegWrite, out_control.MemWrite, out_control.MemRead);
    end
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    advance();
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 32'h00002083, 32'h600, 1'b1, 1'b0);
      advance();
      drive(1'b1, 32'h00108133, 32'h604, 1'b1, 1'b0);
      advance();
      drive(1'b1, 32'h00108133, 32'h604, 1'b1, 1'b0);
      advance();
    end
    n_tests++;
    if (stall_count !== 4'hF) begin n_fail++; $display("FAIL sat_count: got %0d want 15", stall_count); end
  endtask

  task automatic test_reset_mid_stall();
    drive(1'b1, 32'h00002083, 32'h700, 1'b1, 1'b0);
    advance();
    drive(1'b1, 32'h00108133, 32'h704, 1'b1, 1'b0);
    #2;
    rst = 1'b0;
    #1;
    model_reset();
    n_tests++;
    if (out_valid !== 1'b0 || stall_count !== '0 || load_use_stall !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset: got v=%b cnt=%0d stall=%b want 0/0/0", out_valid, stall_count, load_use_stall);
    end
    @(negedge clk);
    rst = 1'b1;
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    advance();
  endtask

  task automatic test_random();
    for (int i = 0; i < 800; i++) begin
      drive($urandom_range(0, 3) != 0, rand_instr(), 32'($urandom) & 32'hFFFFFFFC,
            $urandom_range(0, 3) != 0, $urandom_range(0, 11) == 0);
      #1;
      n_tests++;
      if (in_ready !== e_ready) begin
        n_fail++; $display("FAIL rnd_ready[%0d]: got %b want %b", i, in_ready, e_ready);
      end
      n_tests++;
      if (load_use_stall !== e_stall) begin
        n_fail++; $display("FAIL rnd_stall[%0d]: got %b want %b", i, load_use_stall, e_stall);
      end
      advance();
      n_tests++;
      if (out_valid !== m_valid) begin
        n_fail++; $display("FAIL rnd_valid[%0d]: got %b want %b", i, out_valid, m_valid);
      end
      n_tests++;
      if (stall_count !== CNT_W'(m_cnt)) begin
        n_fail++; $display("FAIL rnd_count[%0d]: got %0d want %0d", i, stall_count, m_cnt);
      end
      if (m_valid) begin
        n_tests++;
        if (out_control !== m_ref.ctl || out_illegal !== m_ref.ill) begin
          n_fail++;
          $display("FAIL rnd_ctl[%0d]: ins=%h got ctl=%h ill=%b want ctl=%h ill=%b",
                   i, m_ins, out_control, out_illegal, m_ref.ctl, m_ref.ill);
        end
        if (!m_ref.ill) begin
          n_tests++;
          if (out_imm !== m_ref.imm) begin
            n_fail++; $display("FAIL rnd_imm[%0d]: ins=%h got %h want %h", i, m_ins, out_imm, m_ref.imm);
          end
        end
        n_tests++;
        if (out_pc !== m_pc || out_rs1 !== m_ins[19:15] || out_rs2 !== m_ins[24:20] ||
            out_rd !== m_ins[11:7]) begin
          n_fail++;
          $display("FAIL rnd_fields[%0d]: got pc=%h rs1=%0d rs2=%0d rd=%0d want pc=%h ins=%h",
                   i, out_pc, out_rs1, out_rs2, out_rd, m_pc, m_ins);
        end
      end
    end
  endtask

  initial begin
    rst = 1'b0;
    in_valid = 1'b0; in_instruction = '0; in_pc = '0; out_ready = 1'b0; flush = 1'b0;
    @(negedge clk);
    test_reset();
    test_basic_decode();
    test_imm_sign();
    test_load_use();
    test_backpressure();
    test_flush_hazard();
    test_illegal();
    test_saturation();
    test_reset_mid_stall();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
